// File: rtl/sc_speed_pkg.sv
// Shared definitions for the game-speed scheduler: FSM state encoding and default widths.
package sc_speed_pkg;

    localparam int DEF_DATAWIDTH  = 23;
    localparam int DEF_LEVELWIDTH = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_PAUSE = ST_PAUSE
    } speedState_t;

endpackage

// File: rtl/sc_speed_controller_if.sv
// Control/status bundle between the game FSM / UI debouncers and the speed scheduler.
interface sc_speed_controller_if #(
    parameter int LW = sc_speed_pkg::DEF_LEVELWIDTH
);
    logic          SC_SPEEDCTRL_start_InHigh;
    logic          SC_SPEEDCTRL_stop_InHigh;
    logic          SC_SPEEDCTRL_pause_InHigh;
    logic          SC_SPEEDCTRL_up_InHigh;
    logic          SC_SPEEDCTRL_down_InHigh;
    logic          SC_SPEEDCTRL_ack_InHigh;
    logic          SC_SPEEDCTRL_T0_OutLow;
    logic [LW-1:0] SC_SPEEDCTRL_level_OutBUS;
    logic          SC_SPEEDCTRL_running_OutHigh;
    logic          SC_SPEEDCTRL_overrun_OutHigh;

    modport master (
        output SC_SPEEDCTRL_start_InHigh, SC_SPEEDCTRL_stop_InHigh, SC_SPEEDCTRL_pause_InHigh,
               SC_SPEEDCTRL_up_InHigh, SC_SPEEDCTRL_down_InHigh, SC_SPEEDCTRL_ack_InHigh,
        input  SC_SPEEDCTRL_T0_OutLow, SC_SPEEDCTRL_level_OutBUS,
               SC_SPEEDCTRL_running_OutHigh, SC_SPEEDCTRL_overrun_OutHigh
    );

    modport slave (
        input  SC_SPEEDCTRL_start_InHigh, SC_SPEEDCTRL_stop_InHigh, SC_SPEEDCTRL_pause_InHigh,
               SC_SPEEDCTRL_up_InHigh, SC_SPEEDCTRL_down_InHigh, SC_SPEEDCTRL_ack_InHigh,
        output SC_SPEEDCTRL_T0_OutLow, SC_SPEEDCTRL_level_OutBUS,
               SC_SPEEDCTRL_running_OutHigh, SC_SPEEDCTRL_overrun_OutHigh
    );
endinterface

// File: rtl/sc_speed_counter.sv
// Free-running period counter; the period shrinks by half per speed level and wraps at P-1.
module sc_speed_counter #(
    parameter int                   DW   = sc_speed_pkg::DEF_DATAWIDTH,
    parameter int                   LW   = sc_speed_pkg::DEF_LEVELWIDTH,
    parameter logic [DW-1:0]        BASE = 23'h7FFFFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [LW-1:0] level,
    output logic          tc
);

    logic [DW-1:0] count;
    logic [DW-1:0] period;

    // Deep levels would shift the period to 0 or 1; clamp so a tick never fires every cycle.
    function automatic logic [DW-1:0] periodOf(input logic [LW-1:0] lvl);
        logic [DW-1:0] p;
        p = BASE >> lvl;
        if (p < DW'(2))
            p = DW'(2);
        return p;
    endfunction

    assign period = periodOf(level);
    assign tc     = (count == period - DW'(1));

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en)
            count <= tc ? '0 : count + DW'(1);
    end

endmodule

// File: rtl/sc_speed_controller.sv
// Game-speed scheduler: run/pause/stop FSM, speed level, and the acknowledged step tick.
module sc_speed_controller
    import sc_speed_pkg::*;
#(
    parameter int                          SPEED_DATAWIDTH  = DEF_DATAWIDTH,
    parameter int                          SPEED_LEVELS     = 8,
    parameter int                          SPEED_LEVELWIDTH = DEF_LEVELWIDTH,
    parameter logic [SPEED_DATAWIDTH-1:0]  SPEED_BASEPERIOD = 23'h7FFFFF
) (
    input logic                   SC_SPEEDCTRL_CLOCK_50,
    input logic                   SC_SPEEDCTRL_RESET_InHigh,
    sc_speed_controller_if.slave  bus
);

    logic clk, rst;
    assign clk = SC_SPEEDCTRL_CLOCK_50;
    assign rst = SC_SPEEDCTRL_RESET_InHigh;

    speedState_t state, stateNext;
    logic [SPEED_LEVELWIDTH-1:0] level;
    logic t0, overrun, running;
    logic stop, startOk, upOk, downOk, levelChg, tc, periodEvt, cntClr;

    assign stop     = bus.SC_SPEEDCTRL_stop_InHigh;
    assign startOk  = bus.SC_SPEEDCTRL_start_InHigh && !stop && (state == S_IDLE);
    assign upOk     = bus.SC_SPEEDCTRL_up_InHigh && !bus.SC_SPEEDCTRL_down_InHigh
                      && (level != SPEED_LEVELWIDTH'(SPEED_LEVELS - 1));
    assign downOk   = bus.SC_SPEEDCTRL_down_InHigh && !bus.SC_SPEEDCTRL_up_InHigh
                      && (level != '0);
    assign levelChg = upOk || downOk;

    // A level change restarts the period, so it also suppresses a coinciding event.
    assign cntClr    = stop || levelChg || (state == S_IDLE);
    assign periodEvt = (state == S_RUN) && tc && !cntClr;

    sc_speed_counter #(
        .DW   (SPEED_DATAWIDTH),
        .LW   (SPEED_LEVELWIDTH),
        .BASE (SPEED_BASEPERIOD)
    ) uCounter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cntClr),
        .en    (state == S_RUN),
        .level (level),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE:  if (startOk) stateNext = S_RUN;
            S_RUN:   if (stop) stateNext = S_IDLE;
                     else if (bus.SC_SPEEDCTRL_pause_InHigh) stateNext = S_PAUSE;
            S_PAUSE: if (stop) stateNext = S_IDLE;
                     else if (!bus.SC_SPEEDCTRL_pause_InHigh) stateNext = S_RUN;
            default: stateNext = S_IDLE;
        endcase
    end

    // Pending tick is frozen while paused: ack only retires it in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            level   <= '0;
            t0      <= 1'b1;
            overrun <= 1'b0;
            running <= 1'b0;
        end else begin
            running <= (stateNext != S_IDLE);
            if (upOk)
                level <= level + SPEED_LEVELWIDTH'(1);
            else if (downOk)
                level <= level - SPEED_LEVELWIDTH'(1);

            if (stop)
                t0 <= 1'b1;
            else if (periodEvt)
                t0 <= 1'b0;
            else if ((state == S_RUN) && bus.SC_SPEEDCTRL_ack_InHigh)
                t0 <= 1'b1;

            if (startOk)
                overrun <= 1'b0;
            else if (periodEvt && !t0 && !bus.SC_SPEEDCTRL_ack_InHigh)
                overrun <= 1'b1;
        end
    end

    assign bus.SC_SPEEDCTRL_T0_OutLow       = t0;
    assign bus.SC_SPEEDCTRL_level_OutBUS    = level;
    assign bus.SC_SPEEDCTRL_running_OutHigh = running;
    assign bus.SC_SPEEDCTRL_overrun_OutHigh = overrun;

endmodule
